// File: rtl/strobe_gen_multi.sv
// Multi-channel strobe divider: each channel divides the shared strobe_in by (rate+1),
// starting from a per-channel phase, with an optional fixed-length burst mode and a global resync.
module strobe_gen_multi #(
    parameter int NCHAN  = 2,
    parameter int WIDTH  = 16,
    parameter int BWIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NCHAN-1:0]       enable,
    input  logic [NCHAN-1:0]       mode,
    input  logic [NCHAN*WIDTH-1:0] rate,
    input  logic [NCHAN*WIDTH-1:0] phase,
    input  logic [BWIDTH-1:0]      burst_len,
    input  logic                   strobe_in,
    input  logic                   sync,
    output logic [NCHAN-1:0]       strobe,
    output logic [NCHAN-1:0]       done,
    output logic [NCHAN-1:0]       active
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        state_e              state_q, state_d;
        logic [WIDTH-1:0]    cnt_q, cnt_d;
        logic [BWIDTH-1:0]   bcnt_q, bcnt_d;
        logic [BWIDTH-1:0]   blen_q, blen_d;
        logic                mode_q, mode_d;
        logic [WIDTH-1:0]    rate_c, phase_c;
        state_e              arm_state;

        assign rate_c    = rate[c*WIDTH +: WIDTH];
        assign phase_c   = phase[c*WIDTH +: WIDTH];
        // A burst of zero length completes the moment it is armed.
        assign arm_state = (mode[c] && (burst_len == '0)) ? S_DONE : S_RUN;

        always_comb begin
            // NOTE: every next-state value is defaulted to hold first so no path infers a latch.
            state_d = state_q;
            cnt_d   = cnt_q;
            bcnt_d  = bcnt_q;
            mode_d  = mode_q;
            blen_d  = blen_q;
            if (state_q == S_IDLE) begin
                cnt_d  = phase_c;
                bcnt_d = '0;
                mode_d = mode[c];
                blen_d = burst_len;
                if (enable[c]) begin
                    state_d = arm_state;
                end
            end else if (!enable[c]) begin
                state_d = S_IDLE;
            end else if (sync) begin
                cnt_d   = phase_c;
                bcnt_d  = '0;
                mode_d  = mode[c];
                blen_d  = burst_len;
                state_d = arm_state;
            end else if ((state_q == S_RUN) && strobe_in) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Rate is only sampled at wrap so a change never shortens a running period.
                    cnt_d = rate_c;
                    if (mode_q) begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_d == blen_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
        end

        // NOTE: state registers use non-blocking assignments and reset asynchronously to IDLE.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                bcnt_q  <= '0;
                mode_q  <= 1'b0;
                blen_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                bcnt_q  <= bcnt_d;
                mode_q  <= mode_d;
                blen_q  <= blen_d;
            end
        end

        assign strobe[c] = (state_q == S_RUN) && strobe_in && (cnt_q == '0) && !sync;
        assign done[c]   = (state_q == S_DONE);
        assign active[c] = (state_q == S_RUN);
    end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Self-checking bench for strobe_gen_multi: directed scenarios with spec-derived strobe positions
// plus randomized traffic compared cycle by cycle against a behavioural channel model.
module tb_strobe_gen_multi;

    localparam int NCHAN  = 2;
    localparam int WIDTH  = 16;
    localparam int BWIDTH = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NCHAN-1:0]       enable;
    logic [NCHAN-1:0]       mode;
    logic [NCHAN*WIDTH-1:0] rate;
    logic [NCHAN*WIDTH-1:0] phase;
    logic [BWIDTH-1:0]      burst_len;
    logic                   strobe_in;
    logic                   sync;
    logic [NCHAN-1:0]       strobe;
    logic [NCHAN-1:0]       done;
    logic [NCHAN-1:0]       active;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural view of each channel: where it is, strobe_ins left before the next strobe,
    // strobes emitted in the current burst, and the burst settings captured at arm time.
    int m_st   [NCHAN];
    int m_left [NCHAN];
    int m_sent [NCHAN];
    int m_burst[NCHAN];
    int m_len  [NCHAN];

    strobe_gen_multi #(.NCHAN(NCHAN), .WIDTH(WIDTH), .BWIDTH(BWIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode),
        .rate      (rate),
        .phase     (phase),
        .burst_len (burst_len),
        .strobe_in (strobe_in),
        .sync      (sync),
        .strobe    (strobe),
        .done      (done),
        .active    (active)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int c = 0; c < NCHAN; c++) begin
            m_st[c] = M_IDLE; m_left[c] = 0; m_sent[c] = 0; m_burst[c] = 0; m_len[c] = 0;
        end
    endtask

    function automatic logic [3*NCHAN-1:0] model_out();
        logic [NCHAN-1:0] s, d, a;
        for (int c = 0; c < NCHAN; c++) begin
            s[c] = (m_st[c] == M_RUN) && strobe_in && (m_left[c] == 0) && !sync;
            d[c] = (m_st[c] == M_DONE);
            a[c] = (m_st[c] == M_RUN);
        end
        return {s, d, a};
    endfunction

    task automatic model_arm(input int c);
        m_left[c]  = int'(phase[c*WIDTH +: WIDTH]);
        m_sent[c]  = 0;
        m_burst[c] = int'(mode[c]);
        m_len[c]   = int'(burst_len);
        m_st[c]    = (mode[c] && burst_len == 0) ? M_DONE : M_RUN;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic tick();
        @(posedge clock);
        for (int c = 0; c < NCHAN; c++) begin
            if (m_st[c] == M_IDLE) begin
                if (enable[c]) model_arm(c);
            end else if (!enable[c]) begin
                m_st[c] = M_IDLE;
            end else if (sync) begin
                model_arm(c);
            end else if (m_st[c] == M_RUN && strobe_in) begin
                if (m_left[c] > 0) begin
                    m_left[c]--;
                end else begin
                    m_left[c] = int'(rate[c*WIDTH +: WIDTH]);
                    if (m_burst[c] != 0) begin
                        m_sent[c]++;
                        if (m_sent[c] == m_len[c]) m_st[c] = M_DONE;
                    end
                end
            end
        end
    endtask

    task automatic apply(input logic [1:0] en, input logic [1:0] md, input int r0, input int r1,
                         input int p0, input int p1, input int bl, input logic si, input logic sy);
        @(negedge clock);
        enable    = en;
        mode      = md;
        rate      = {r1[15:0], r0[15:0]};
        phase     = {p1[15:0], p0[15:0]};
        burst_len = bl[15:0];
        strobe_in = si;
        sync      = sy;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(2'b11, 2'b00, 0, 0, 0, 0, 1, 1'b1, 1'b0);
            n_checks++;
            if ({strobe, done, active} !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, {strobe, done, active}, 6'b0);
            end
        end
        @(negedge clock);
        enable  = 2'b00;
        reset_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({strobe, done, active} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_release got=%b want=%b", {strobe, done, active}, 6'b0);
        end
        tick();
    endtask

    task automatic test_continuous();
        logic want;
        idle(2);
        for (int k = 0; k < 13; k++) begin
            apply(2'b01, 2'b00, 3, 0, 0, 0, 0, 1'b1, 1'b0);
            want = (k >= 1) && ((k - 1) % 4 == 0);
            n_checks++;
            if (strobe[0] !== want || active[0] !== (k >= 1)) begin
                n_errors++;
                $display("FAIL continuous k=%0d strobe0=%b active0=%b want %b/%b", k, strobe[0], active[0], want, k >= 1);
            end
            n_checks++;
            if ({strobe, done, active} !== model_out()) begin
                n_errors++;
                $display("FAIL continuous_model k=%0d got=%b want=%b", k, {strobe, done, active}, model_out());
            end
            tick();
        end
    endtask

    task automatic test_phase();
        logic want;
        idle(2);
        for (int k = 0; k < 22; k++) begin
            apply(2'b10, 2'b00, 0, 4, 0, 2, 0, logic'(k % 2 == 1), 1'b0);
            want = (k == 5) || (k == 15);
            n_checks++;
            if (strobe[1] !== want) begin
                n_errors++;
                $display("FAIL phase k=%0d strobe1=%b want=%b", k, strobe[1], want);
            end
            tick();
        end
    endtask

    task automatic test_burst();
        logic want;
        idle(2);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 10; k++) begin
                apply(2'b01, 2'b01, 1, 0, 0, 0, 3, 1'b1, 1'b0);
                want = (k == 1) || (k == 3) || (k == 5);
                n_checks++;
                if (strobe[0] !== want || done[0] !== (k >= 6) || active[0] !== (k >= 1 && k < 6)) begin
                    n_errors++;
                    $display("FAIL burst pass=%0d k=%0d s/d/a=%b%b%b want %b%b%b", pass, k,
                             strobe[0], done[0], active[0], want, k >= 6, k >= 1 && k < 6);
                end
                tick();
            end
            apply(2'b00, 2'b01, 1, 0, 0, 0, 3, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_rate_change();
        logic want;
        idle(2);
        for (int k = 0; k < 21; k++) begin
            apply(2'b01, 2'b00, (k >= 3) ? 7 : 3, 0, 0, 0, 0, 1'b1, 1'b0);
            want = (k == 1) || (k == 5) || (k == 13);
            n_checks++;
            if (strobe[0] !== want) begin
                n_errors++;
                $display("FAIL rate_change k=%0d strobe0=%b want=%b", k, strobe[0], want);
            end
            tick();
        end
    endtask

    task automatic test_sync();
        logic [1:0] want;
        idle(2);
        for (int k = 0; k < 15; k++) begin
            apply(2'b11, 2'b00, 3, 4, 0, 2, 0, 1'b1, logic'(k == 5));
            want[0] = (k == 1) || (k == 6) || (k == 10) || (k == 14);
            want[1] = (k == 3) || (k == 8) || (k == 13);
            n_checks++;
            if (strobe !== want) begin
                n_errors++;
                $display("FAIL sync k=%0d strobe=%b want=%b", k, strobe, want);
            end
            tick();
        end
    endtask

    task automatic test_burst_zero_and_reset();
        idle(2);
        for (int k = 0; k < 6; k++) begin
            apply(2'b01, 2'b01, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            n_checks++;
            if (strobe[0] !== 1'b0 || done[0] !== (k >= 1) || active[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL burst_zero k=%0d s/d/a=%b%b%b want 0%b0", k, strobe[0], done[0], active[0], k >= 1);
            end
            tick();
        end
        idle(2);
        for (int k = 0; k < 5; k++) begin
            apply(2'b10, 2'b10, 0, 2, 0, 0, 5, 1'b1, 1'b0);
            n_checks++;
            if ({strobe, done, active} !== model_out()) begin
                n_errors++;
                $display("FAIL mid_burst k=%0d got=%b want=%b", k, {strobe, done, active}, model_out());
            end
            tick();
        end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({strobe, done, active} !== 6'b0) begin
            n_errors++;
            $display("FAIL async_reset got=%b want=%b", {strobe, done, active}, 6'b0);
        end
        @(posedge clock);
        @(negedge clock);
        enable  = 2'b00;
        reset_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({strobe, done, active} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_idle got=%b want=%b", {strobe, done, active}, 6'b0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] en, md;
        int r0, r1, p0, p1, bl;
        r0 = 2; r1 = 3; p0 = 0; p1 = 1; bl = 2;
        md = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            en = {logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 15) != 0)};
            if ($urandom_range(0, 9) == 0) begin
                r0 = $urandom_range(0, 5); r1 = $urandom_range(0, 5);
                p0 = $urandom_range(0, 7); p1 = $urandom_range(0, 7);
                bl = $urandom_range(0, 4); md = 2'($urandom_range(0, 3));
            end
            apply(en, md, r0, r1, p0, p1, bl, logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 19) == 0));
            n_checks++;
            if ({strobe, done, active} !== model_out()) begin
                n_errors++;
                $display("FAIL random k=%0d got=%b want=%b", k, {strobe, done, active}, model_out());
            end
            tick();
        end
    endtask

    initial begin
        enable = '0; mode = '0; rate = '0; phase = '0; burst_len = '0;
        strobe_in = 1'b0; sync = 1'b0;
        model_reset();
        test_reset();
        test_continuous();
        test_phase();
        test_burst();
        test_rate_change();
        test_sync();
        test_burst_zero_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
